pid_plant_emulator: RTL and testbench
=====================================

PID_PLANT_EMULATOR -- requirements
Module: pid_plant_emulator

Interface
REQ-001 Parameter TICK_DIV, default 16, clocks spent in IDLE per plant update (2..255).
REQ-002 Parameter SHIFT, default 2, first-order lag coefficient as right-shift amount (1..7).
REQ-003 Parameter DELAY, default 4, transport-delay depth in updates (1..8).
REQ-004 clk  in  1  clock, rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 u_in  in  8  unsigned control word from the controller.
REQ-007 u_valid  in  1  u_in is valid.
REQ-008 u_ready  out  1  emulator accepts u_in this cycle.
REQ-009 dist_in  in  8  signed two's-complement disturbance added at the output.
REQ-010 y_out  out  8  unsigned emulated feedback, registered.
REQ-011 y_valid  out  1  one-cycle pulse when y_out is updated.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT, CALC and OUTPUT: IDLE->SHIFT at tick terminal count, then SHIFT->CALC->OUTPUT->IDLE unconditionally.
REQ-013 The tick counter SHALL count 0..TICK_DIV-1 only in IDLE and SHALL clear on leaving IDLE, giving a y_valid period of exactly TICK_DIV+3 clocks.
REQ-014 u_ready SHALL equal 1 only in IDLE; a transfer occurs when u_valid and u_ready are both 1, loading u_in into u_hold; u_hold keeps its value until the next transfer.
REQ-015 A transfer in the same cycle as the IDLE terminal count SHALL be used by that update.
REQ-016 SHIFT SHALL push u_hold into delay-line entry 0 and move entry i-1 to entry i; u_d is entry DELAY-1 after the shift.
REQ-017 CALC SHALL update the 16-bit unsigned accumulator acc (8.8 fixed point): acc <= acc + ((({u_d,8'h00} - acc) as signed 17-bit) >>> SHIFT), arithmetic shift, truncating toward minus infinity.
REQ-018 OUTPUT SHALL set y_out = saturate(acc[15:8] + sign-extended dist_in) clamped to 0..255, and SHALL assert y_valid for that one cycle.
REQ-019 dist_in SHALL be sampled only in OUTPUT; changes at any other time SHALL NOT affect y_out.
REQ-020 acc SHALL never wrap; by construction it stays within 0..0xFFFF.

Reset
REQ-021 While rst_n=0: state=IDLE, tick counter=0, u_hold=0, all delay entries=0, acc=0, y_out=0, y_valid=0, u_ready=1.
REQ-022 Reset asserted in any state, including mid-update, SHALL abort the update immediately with no y_valid pulse; the first y_valid after release SHALL occur TICK_DIV+3 clocks after the first rising edge with rst_n=1.

Configuration
REQ-023 Macro PLANT_NOISE_EN: when defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11, reset seed 16'hACE1) SHALL advance once per OUTPUT, and its bits [2:0], taken as signed -4..+3, SHALL be added inside the REQ-018 sum before saturation.
REQ-024 Without PLANT_NOISE_EN, the LFSR SHALL be absent and y_out SHALL be fully deterministic per REQ-018.

Verification (defaults, PLANT_NOISE_EN undefined unless stated)
REQ-025 Reset release, u_valid=0 -> y_out=0, u_ready=1; first y_valid on clock 19; subsequent pulses every 19 clocks.
REQ-026 Step u_in=200 accepted before update 1, dist=0 -> y_out=0 for updates 1-3, 50 at update 4, 87 at update 5, monotonic rise toward 199.
REQ-027 Saturation: u=250 held for 100 updates, dist=+20 -> y_out=255; u=0 settled, dist=-128 -> y_out=0.
REQ-028 Handshake: u_valid=1 held from SHIFT entry -> u_ready=0 through SHIFT/CALC/OUTPUT, transfer on first IDLE cycle, value applied at next update, not the current one.
REQ-029 Reset asserted during CALC -> no y_valid pulse; acc, delay line and y_out read 0 at release; timing per REQ-025.
REQ-030 PLANT_NOISE_EN defined, u=128 settled, dist=0 -> every y_out within 123..130 and not constant over 16 updates.

Source files
------------

// File: rtl/pid_plant_emulator_if.sv
// Controller <-> plant-emulator bus: control word handshake, disturbance input,
// and the registered feedback word with its update strobe.
interface pid_plant_emulator_if;
    logic [7:0] u_in;
    logic       u_valid;
    logic       u_ready;
    logic [7:0] dist_in;
    logic [7:0] y_out;
    logic       y_valid;

    // Controller side
    modport master (
        output u_in, u_valid, dist_in,
        input  u_ready, y_out, y_valid
    );

    // Emulator side
    modport slave (
        input  u_in, u_valid, dist_in,
        output u_ready, y_out, y_valid
    );
endinterface

// File: rtl/pid_plant_emulator.sv
// First-order-lag plant with transport delay, for closed-loop PID testing.
// One plant update every TICK_DIV+3 clocks: IDLE (TICK_DIV clocks) -> SHIFT
// (delay line) -> CALC (lag filter) -> OUTPUT (disturbance add + saturate).
// Optional build macro PLANT_NOISE_EN adds LFSR noise of -4..+3 to y_out.
module pid_plant_emulator #(
    parameter int TICK_DIV = 16,
    parameter int SHIFT    = 2,
    parameter int DELAY    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pid_plant_emulator_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CALC,
        ST_OUTPUT
    } state_e;

    localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);

    state_e state_q, state_d;

    logic [7:0]  tick_q, tick_d;
    logic [7:0]  u_hold_q, u_hold_d;
    logic [7:0]  dly_q [DELAY];
    logic [7:0]  dly_d [DELAY];
    logic [15:0] acc_q, acc_d;
    logic [7:0]  y_out_q, y_out_d;
    logic        y_valid_q, y_valid_d;

    logic        tick_done;
    logic        u_ready;
    logic        do_shift;
    logic        do_calc;
    logic        do_output;
    logic        xfer;

    logic [7:0]         u_d;
    logic signed [16:0] diff;
    logic signed [16:0] step;
    logic signed [10:0] noise;
    logic signed [10:0] y_sum;
    logic [7:0]         y_sat;

    assign tick_done = (state_q == ST_IDLE) && (tick_q == TICK_LAST);
    assign xfer      = bus.u_valid && u_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: only IDLE waits; the update phases run back to back
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (tick_done) state_d = ST_SHIFT;
            ST_SHIFT:  state_d = ST_CALC;
            ST_CALC:   state_d = ST_OUTPUT;
            ST_OUTPUT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State decode into handshake and datapath strobes
    always_comb begin
        u_ready   = 1'b0;
        do_shift  = 1'b0;
        do_calc   = 1'b0;
        do_output = 1'b0;
        case (state_q)
            ST_IDLE:   u_ready   = 1'b1;
            ST_SHIFT:  do_shift  = 1'b1;
            ST_CALC:   do_calc   = 1'b1;
            ST_OUTPUT: do_output = 1'b1;
            default:   u_ready   = 1'b0;
        endcase
    end

    // Lag filter: difference kept 17-bit signed so the arithmetic shift
    // rounds toward minus infinity and the accumulator can never wrap.
    assign u_d  = dly_q[DELAY-1];
    assign diff = $signed({1'b0, u_d, 8'h00}) - $signed({1'b0, acc_q});
    assign step = diff >>> SHIFT;

`ifdef PLANT_NOISE_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Noise source: Fibonacci LFSR x^16+x^14+x^13+x^11, one step per update
    always_comb begin
        lfsr_d = lfsr_q;
        if (do_output) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    // LFSR register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign noise = $signed({{8{lfsr_q[2]}}, lfsr_q[2:0]});
`else
    assign noise = '0;
`endif

    // Output stage: plant position plus disturbance (and noise), clamped to 0..255
    always_comb begin
        y_sum = $signed({3'b000, acc_q[15:8]})
              + $signed({{3{bus.dist_in[7]}}, bus.dist_in})
              + noise;
        if (y_sum < 11'sd0) begin
            y_sat = '0;
        end else if (y_sum > 11'sd255) begin
            y_sat = '1;
        end else begin
            y_sat = y_sum[7:0];
        end
    end

    // Datapath next-state: tick counter, input hold, delay line, accumulator, output
    always_comb begin
        tick_d    = '0;
        u_hold_d  = u_hold_q;
        dly_d     = dly_q;
        acc_d     = acc_q;
        y_out_d   = y_out_q;
        y_valid_d = 1'b0;

        if (state_q == ST_IDLE && !tick_done) begin
            tick_d = tick_q + 8'd1;
        end

        if (xfer) begin
            u_hold_d = bus.u_in;
        end

        if (do_shift) begin
            dly_d[0] = u_hold_q;
            for (int unsigned i = 1; i < DELAY; i++) begin
                dly_d[i] = dly_q[i-1];
            end
        end

        if (do_calc) begin
            acc_d = 16'($signed({1'b0, acc_q}) + step);
        end

        if (do_output) begin
            y_out_d   = y_sat;
            y_valid_d = 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q    <= '0;
            u_hold_q  <= '0;
            for (int unsigned i = 0; i < DELAY; i++) begin
                dly_q[i] <= '0;
            end
            acc_q     <= '0;
            y_out_q   <= '0;
            y_valid_q <= 1'b0;
        end else begin
            tick_q    <= tick_d;
            u_hold_q  <= u_hold_d;
            dly_q     <= dly_d;
            acc_q     <= acc_d;
            y_out_q   <= y_out_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign bus.u_ready = u_ready;
    assign bus.y_out   = y_out_q;
    assign bus.y_valid = y_valid_q;

endmodule

// File: tb/tb_pid_plant_emulator.sv
// Directed bench for pid_plant_emulator with default parameters
// (TICK_DIV=16, SHIFT=2, DELAY=4); expected values worked out by hand.
module tb_pid_plant_emulator;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    pid_plant_emulator_if bus_if ();

    pid_plant_emulator #(
        .TICK_DIV (16),
        .SHIFT    (2),
        .DELAY    (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and sample 1 ns after the rising edge
    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    // Advance to the next y_valid pulse; n = edges taken, -1 on timeout
    task automatic wait_yvalid(output int n);
        n = 0;
        do begin
            tick1();
            n++;
        end while (!bus_if.y_valid && n < 200);
        if (!bus_if.y_valid) begin
            n = -1;
            total++;
            bad++;
            $display("FAIL y_valid_timeout: no y_valid within 200 clocks");
        end
    endtask

    // Load one control word while the emulator is in IDLE
    task automatic send_u(input logic [7:0] val);
        bus_if.u_in    = val;
        bus_if.u_valid = 1'b1;
        tick1();
        bus_if.u_valid = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst_n          = 1'b0;
        bus_if.u_in    = '0;
        bus_if.u_valid = 1'b0;
        bus_if.dist_in = '0;
        repeat (3) tick1();
        total++;
        if (bus_if.y_out !== 8'd0) begin
            bad++; $display("FAIL reset_y_out: got %0d want 0", bus_if.y_out);
        end
        total++;
        if (bus_if.y_valid !== 1'b0) begin
            bad++; $display("FAIL reset_y_valid: got %b want 0", bus_if.y_valid);
        end
        total++;
        if (bus_if.u_ready !== 1'b1) begin
            bad++; $display("FAIL reset_u_ready: got %b want 1", bus_if.u_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_yvalid(n);
        total++;
        if (n !== 19) begin
            bad++; $display("FAIL first_valid_latency: got %0d want 19", n);
        end
        total++;
        if (bus_if.u_ready !== 1'b1) begin
            bad++; $display("FAIL idle_u_ready: got %b want 1", bus_if.u_ready);
        end
        tick1();
        total++;
        if (bus_if.y_valid !== 1'b0) begin
            bad++; $display("FAIL y_valid_width: got %b want 0", bus_if.y_valid);
        end
        wait_yvalid(n);
        total++;
        if (n !== 18) begin
            bad++; $display("FAIL valid_period: got %0d want 18 after pulse+1", n);
        end
    endtask

    task automatic test_step();
        int n;
        int prev;
        int exp_y [7] = '{0, 0, 0, 50, 87, 115, 136};
        send_u(8'd200);
        for (int k = 0; k < 7; k++) begin
            wait_yvalid(n);
            total++;
            if (bus_if.y_out !== 8'(exp_y[k])) begin
                bad++; $display("FAIL step_update%0d: got %0d want %0d", k + 1, bus_if.y_out, exp_y[k]);
            end
        end
        prev = 136;
        for (int k = 0; k < 50; k++) begin
            wait_yvalid(n);
            total++;
            if (int'(bus_if.y_out) < prev) begin
                bad++; $display("FAIL step_monotonic: got %0d want >= %0d", bus_if.y_out, prev);
            end
            prev = int'(bus_if.y_out);
        end
        total++;
        if (bus_if.y_out !== 8'd199) begin
            bad++; $display("FAIL step_settled: got %0d want 199", bus_if.y_out);
        end
    endtask

    task automatic test_dist();
        int n;
        logic held;
        bus_if.dist_in = 8'sd20;
        held = 1'b1;
        repeat (10) begin
            tick1();
            if (bus_if.y_out !== 8'd199) held = 1'b0;
        end
        total++;
        if (held !== 1'b1) begin
            bad++; $display("FAIL dist_idle_hold: got %0d want 199", bus_if.y_out);
        end
        wait_yvalid(n);
        total++;
        if (bus_if.y_out !== 8'd219) begin
            bad++; $display("FAIL dist_plus20: got %0d want 219", bus_if.y_out);
        end
        bus_if.dist_in = 8'hCE;
        wait_yvalid(n);
        total++;
        if (bus_if.y_out !== 8'd149) begin
            bad++; $display("FAIL dist_minus50: got %0d want 149", bus_if.y_out);
        end
        bus_if.dist_in = 8'sd100;
        wait_yvalid(n);
        total++;
        if (bus_if.y_out !== 8'd255) begin
            bad++; $display("FAIL dist_sat_high: got %0d want 255", bus_if.y_out);
        end
        bus_if.dist_in = 8'h80;
        wait_yvalid(n);
        total++;
        if (bus_if.y_out !== 8'd71) begin
            bad++; $display("FAIL dist_minus128: got %0d want 71", bus_if.y_out);
        end
        bus_if.dist_in = 8'sd100;
        repeat (5) tick1();
        bus_if.dist_in = '0;
        wait_yvalid(n);
        total++;
        if (bus_if.y_out !== 8'd199) begin
            bad++; $display("FAIL dist_sample_only_output: got %0d want 199", bus_if.y_out);
        end
    endtask

    task automatic test_saturation();
        int n;
        send_u(8'd250);
        bus_if.dist_in = 8'sd20;
        repeat (100) wait_yvalid(n);
        total++;
        if (bus_if.y_out !== 8'd255) begin
            bad++; $display("FAIL sat_high: got %0d want 255", bus_if.y_out);
        end
        bus_if.dist_in = '0;
        wait_yvalid(n);
        total++;
        if (bus_if.y_out !== 8'd249) begin
            bad++; $display("FAIL settled_250: got %0d want 249", bus_if.y_out);
        end
        send_u(8'd0);
        repeat (99) wait_yvalid(n);
        bus_if.dist_in = 8'h80;
        wait_yvalid(n);
        total++;
        if (bus_if.y_out !== 8'd0) begin
            bad++; $display("FAIL sat_low: got %0d want 0", bus_if.y_out);
        end
        bus_if.dist_in = '0;
        wait_yvalid(n);
        total++;
        if (bus_if.y_out !== 8'd0) begin
            bad++; $display("FAIL settled_0: got %0d want 0", bus_if.y_out);
        end
    endtask

    task automatic test_handshake();
        int n;
        int exp_y [4] = '{0, 0, 0, 25};
        repeat (15) tick1();
        total++;
        if (bus_if.u_ready !== 1'b1) begin
            bad++; $display("FAIL hs_ready_terminal: got %b want 1", bus_if.u_ready);
        end
        tick1();
        bus_if.u_in    = 8'd100;
        bus_if.u_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (bus_if.u_ready !== 1'b0) begin
                bad++; $display("FAIL hs_ready_busy%0d: got %b want 0", k, bus_if.u_ready);
            end
            tick1();
        end
        total++;
        if (bus_if.y_valid !== 1'b1) begin
            bad++; $display("FAIL hs_update_strobe: got %b want 1", bus_if.y_valid);
        end
        total++;
        if (bus_if.u_ready !== 1'b1) begin
            bad++; $display("FAIL hs_ready_reidle: got %b want 1", bus_if.u_ready);
        end
        tick1();
        bus_if.u_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_yvalid(n);
            total++;
            if (bus_if.y_out !== 8'(exp_y[k])) begin
                bad++; $display("FAIL hs_update%0d: got %0d want %0d", k + 1, bus_if.y_out, exp_y[k]);
            end
        end
    endtask

    task automatic test_reset_mid_calc();
        int n;
        logic quiet;
        int exp_y [3] = '{0, 0, 50};
        repeat (17) tick1();
        rst_n = 1'b0;
        #1;
        total++;
        if (bus_if.y_out !== 8'd0) begin
            bad++; $display("FAIL rst_calc_y_out: got %0d want 0", bus_if.y_out);
        end
        quiet = 1'b1;
        repeat (4) begin
            tick1();
            if (bus_if.y_valid !== 1'b0) quiet = 1'b0;
        end
        total++;
        if (quiet !== 1'b1) begin
            bad++; $display("FAIL rst_calc_no_pulse: got y_valid=1 want 0");
        end
        total++;
        if (bus_if.u_ready !== 1'b1) begin
            bad++; $display("FAIL rst_calc_u_ready: got %b want 1", bus_if.u_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // Offer u=200 exactly on the terminal-count cycle of update 1
        n = 0;
        repeat (15) begin
            tick1();
            n++;
            if (bus_if.y_valid) quiet = 1'b0;
        end
        bus_if.u_in    = 8'd200;
        bus_if.u_valid = 1'b1;
        tick1();
        n++;
        bus_if.u_valid = 1'b0;
        while (!bus_if.y_valid && n < 200) begin
            tick1();
            n++;
        end
        total++;
        if (n !== 19) begin
            bad++; $display("FAIL rst_calc_latency: got %0d want 19", n);
        end
        total++;
        if (bus_if.y_out !== 8'd0) begin
            bad++; $display("FAIL rst_calc_update1: got %0d want 0", bus_if.y_out);
        end
        for (int k = 0; k < 3; k++) begin
            wait_yvalid(n);
            total++;
            if (bus_if.y_out !== 8'(exp_y[k])) begin
                bad++; $display("FAIL rst_calc_update%0d: got %0d want %0d", k + 2, bus_if.y_out, exp_y[k]);
            end
        end
    endtask

`ifdef PLANT_NOISE_EN
    task automatic test_noise();
        int n;
        logic varied;
        logic [7:0] first_y;
        send_u(8'd128);
        repeat (50) wait_yvalid(n);
        first_y = bus_if.y_out;
        varied  = 1'b0;
        for (int k = 0; k < 16; k++) begin
            wait_yvalid(n);
            total++;
            if (bus_if.y_out < 8'd123 || bus_if.y_out > 8'd130) begin
                bad++; $display("FAIL noise_range%0d: got %0d want 123..130", k, bus_if.y_out);
            end
            if (bus_if.y_out !== first_y) varied = 1'b1;
        end
        total++;
        if (varied !== 1'b1) begin
            bad++; $display("FAIL noise_varies: got constant %0d want varying", first_y);
        end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
`ifdef PLANT_NOISE_EN
        test_noise();
`else
        test_step();
        test_dist();
        test_saturation();
        test_handshake();
        test_reset_mid_calc();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
